// File: rtl/univ_reg_pkg.sv
// +----------------------------------------------------------------------------
// | univ_reg_pkg : operation-mode encodings shared by univ_reg and its helpers
// | Revision     : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package univ_reg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_INC  = 3'b110,
      MODE_DEC  = 3'b111
   } mode_t;

endpackage

`default_nettype wire

// File: rtl/univ_reg_next.sv
// +----------------------------------------------------------------------------
// | univ_reg_next : combinational next-state function of the universal register
// | Revision      : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module univ_reg_next #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic [2:0]       mode,
   output logic [WIDTH-1:0] q_nxt,
   output logic             sout_nxt,
   output logic             sout_upd,
   output logic             wrap
);
   import univ_reg_pkg::*;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      q_nxt    = q;
      sout_nxt = 1'b0;
      sout_upd = 1'b0;
      wrap     = 1'b0;
      case (mode_t'(mode))
         MODE_HOLD: q_nxt = q;
         MODE_LOAD: q_nxt = d;
         MODE_SHL: begin
            q_nxt    = {q[WIDTH-2:0], sin};
            sout_nxt = q[WIDTH-1];
            sout_upd = 1'b1;
         end
         MODE_SHR: begin
            q_nxt    = {sin, q[WIDTH-1:1]};
            sout_nxt = q[0];
            sout_upd = 1'b1;
         end
         MODE_ROL: begin
            q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
            sout_nxt = q[WIDTH-1];
            sout_upd = 1'b1;
         end
         MODE_ROR: begin
            q_nxt    = {q[0], q[WIDTH-1:1]};
            sout_nxt = q[0];
            sout_upd = 1'b1;
         end
         MODE_INC: begin
            q_nxt = q + ONE;
            wrap  = &q;
         end
         MODE_DEC: begin
            q_nxt = q - ONE;
            wrap  = ~|q;
         end
         default: q_nxt = q;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/univ_reg.sv
// +----------------------------------------------------------------------------
// | univ_reg : WIDTH-bit universal register (hold/load/shift/rotate/count) with
// |            registered complement, serial-out, terminal-count and, when
// |            UNIV_REG_PARITY_EN is defined, a registered parity output.
// | Revision : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module univ_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic             sout,
   output logic             tc
`ifdef UNIV_REG_PARITY_EN
   ,
   output logic             parity
`endif
);
   import univ_reg_pkg::*;

   logic [WIDTH-1:0] reg_q, reg_d;
   logic [WIDTH-1:0] qn_q, qn_d;
   logic             sout_q, sout_d;
   logic             tc_q, tc_d;

   logic [WIDTH-1:0] q_nxt;
   logic             sout_nxt;
   logic             sout_upd;
   logic             wrap;

   univ_reg_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .q        (reg_q),
      .d        (d),
      .sin      (sin),
      .mode     (mode),
      .q_nxt    (q_nxt),
      .sout_nxt (sout_nxt),
      .sout_upd (sout_upd),
      .wrap     (wrap)
   );

   // Priority: clr > en==0 (hold) > mode; tc clears on any enabled non-wrap edge.
   always_comb begin
      reg_d  = reg_q;
      sout_d = sout_q;
      tc_d   = tc_q;
      if (clr) begin
         reg_d  = RST_VAL;
         sout_d = 1'b0;
         tc_d   = 1'b0;
      end else if (en) begin
         reg_d = q_nxt;
         tc_d  = wrap;
         if (sout_upd) begin
            sout_d = sout_nxt;
         end
      end
      qn_d = ~reg_d;
   end

   // The complement is its own flop so q_n never depends combinationally on q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_q  <= RST_VAL;
         qn_q   <= ~RST_VAL;
         sout_q <= 1'b0;
         tc_q   <= 1'b0;
      end else begin
         reg_q  <= reg_d;
         qn_q   <= qn_d;
         sout_q <= sout_d;
         tc_q   <= tc_d;
      end
   end

   assign q    = reg_q;
   assign q_n  = qn_q;
   assign sout = sout_q;
   assign tc   = tc_q;

`ifdef UNIV_REG_PARITY_EN
   logic parity_q, parity_d;

   assign parity_d = ^reg_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_q <= ^RST_VAL;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity = parity_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_univ_reg.sv
// +----------------------------------------------------------------------------
// | tb_univ_reg : vector table, reset corner cases and randomized run against
// |               an arithmetic reference model of univ_reg (WIDTH=8, RST_VAL=A5)
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_univ_reg;
   import univ_reg_pkg::*;

   localparam int         W   = 8;
   localparam logic [7:0] RST = 8'hA5;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic         clr;
   logic [2:0]   mode;
   logic [W-1:0] d;
   logic         sin;
   logic [W-1:0] q;
   logic [W-1:0] q_n;
   logic         sout;
   logic         tc;
`ifdef UNIV_REG_PARITY_EN
   logic         parity;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_q;
   int m_sout;
   int m_tc;

   always #5 clk = ~clk;

   univ_reg #(
      .WIDTH   (W),
      .RST_VAL (RST)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .clr    (clr),
      .mode   (mode),
      .d      (d),
      .sin    (sin),
      .q      (q),
      .q_n    (q_n),
      .sout   (sout),
      .tc     (tc)
`ifdef UNIV_REG_PARITY_EN
      ,
      .parity (parity)
`endif
   );

   typedef struct {
      logic       clr;
      logic       en;
      mode_t      mode;
      logic [7:0] d;
      logic       sin;
      int         exp_q;
      int         exp_sout;
      int         exp_tc;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state(input string tag, input int eq, input int es, input int et);
      check({tag, ".q"}, int'(q), eq);
      check({tag, ".q_n"}, int'(q_n), 255 - eq);
      check({tag, ".sout"}, int'(sout), es);
      check({tag, ".tc"}, int'(tc), et);
`ifdef UNIV_REG_PARITY_EN
      check({tag, ".parity"}, int'(parity), $countones(eq[7:0]) % 2);
`endif
   endtask

   // Behaviour computed with plain arithmetic on integers 0..255.
   task automatic model_step(input logic c, input logic e, input int md, input int dd, input int s);
      int old;
      old = m_q;
      if (c) begin
         m_q = int'(RST); m_sout = 0; m_tc = 0;
      end else if (e) begin
         m_tc = 0;
         case (md)
            0: m_q = old;
            1: m_q = dd;
            2: begin m_sout = old / 128; m_q = (old * 2) % 256 + s;       end
            3: begin m_sout = old % 2;   m_q = old / 2 + s * 128;         end
            4: begin m_sout = old / 128; m_q = (old * 2) % 256 + old / 128; end
            5: begin m_sout = old % 2;   m_q = old / 2 + (old % 2) * 128; end
            6: begin m_tc = (old == 255) ? 1 : 0; m_q = (old + 1) % 256;   end
            default: begin m_tc = (old == 0) ? 1 : 0; m_q = (old + 255) % 256; end
         endcase
      end
   endtask

   task automatic model_reset();
      m_q = int'(RST); m_sout = 0; m_tc = 0;
   endtask

   task automatic drive(input logic c, input logic e, input mode_t md, input logic [7:0] dd, input logic s);
      @(negedge clk);
      clr = c; en = e; mode = md; d = dd; sin = s;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[24];

   initial begin
      vecs[0]  = '{1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 'h81, 0, 0};
      vecs[1]  = '{1'b0, 1'b1, MODE_SHL,  8'h00, 1'b0, 'h02, 1, 0};
      vecs[2]  = '{1'b0, 1'b1, MODE_SHR,  8'h00, 1'b1, 'h81, 0, 0};
      vecs[3]  = '{1'b0, 1'b1, MODE_ROL,  8'h00, 1'b0, 'h03, 1, 0};
      vecs[4]  = '{1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 'h81, 1, 0};
      vecs[5]  = '{1'b0, 1'b1, MODE_ROR,  8'h00, 1'b0, 'hC0, 1, 0};
      vecs[6]  = '{1'b0, 1'b1, MODE_ROR,  8'h00, 1'b1, 'h60, 0, 0};
      vecs[7]  = '{1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 'hFF, 0, 0};
      vecs[8]  = '{1'b0, 1'b1, MODE_INC,  8'h00, 1'b0, 'h00, 0, 1};
      vecs[9]  = '{1'b0, 1'b1, MODE_INC,  8'h00, 1'b0, 'h01, 0, 0};
      vecs[10] = '{1'b0, 1'b1, MODE_LOAD, 8'h00, 1'b0, 'h00, 0, 0};
      vecs[11] = '{1'b0, 1'b1, MODE_DEC,  8'h00, 1'b0, 'hFF, 0, 1};
      vecs[12] = '{1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 'hFF, 0, 1};
      vecs[13] = '{1'b0, 1'b0, MODE_LOAD, 8'h12, 1'b0, 'hFF, 0, 1};
      vecs[14] = '{1'b0, 1'b0, MODE_SHL,  8'h00, 1'b0, 'hFF, 0, 1};
      vecs[15] = '{1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b0, 'hFF, 0, 0};
      vecs[16] = '{1'b0, 1'b1, MODE_SHL,  8'h00, 1'b1, 'hFF, 1, 0};
      vecs[17] = '{1'b1, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 'hA5, 0, 0};
      vecs[18] = '{1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 'hA5, 0, 0};
      vecs[19] = '{1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 'hA5, 0, 0};
      vecs[20] = '{1'b0, 1'b0, MODE_INC,  8'h00, 1'b0, 'hA5, 0, 0};
      vecs[21] = '{1'b0, 1'b1, MODE_DEC,  8'h00, 1'b0, 'hA4, 0, 0};
      vecs[22] = '{1'b0, 1'b1, MODE_ROL,  8'h00, 1'b1, 'h49, 1, 0};
      vecs[23] = '{1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 'hA5, 0, 0};

      reset = 1'b1; en = 1'b0; clr = 1'b0; mode = MODE_HOLD; d = '0; sin = 1'b0;
      #3;
      check_state("reset_async", 'hA5, 0, 0);
      #4 reset = 1'b0;

      for (int i = 0; i < 24; i++) begin
         drive(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin);
         check_state($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_sout, vecs[i].exp_tc);
      end

      // reset partway through a count, then resume counting
      drive(1'b0, 1'b1, MODE_LOAD, 8'h7E, 1'b0);
      check_state("mid_load", 'h7E, 0, 0);
      drive(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
      check_state("mid_inc", 'h7F, 0, 0);
      #1 reset = 1'b1;
      #1 check_state("mid_reset", 'hA5, 0, 0);
      #1 reset = 1'b0;
      #1 check_state("mid_release", 'hA5, 0, 0);
      @(posedge clk);
      #1 check_state("post_reset_inc", 'hA6, 0, 0);

      // randomized run against the model
      m_q = 'hA6; m_sout = 0; m_tc = 0;
      for (int i = 0; i < 400; i++) begin
         logic       r_c, r_e, r_s;
         logic [2:0] r_m;
         logic [7:0] r_d;
         r_c = ($urandom_range(0, 15) == 0);
         r_e = ($urandom_range(0, 3) != 0);
         r_m = 3'($urandom_range(0, 7));
         r_d = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         r_s = 1'($urandom_range(0, 1));
         drive(r_c, r_e, mode_t'(r_m), r_d, r_s);
         model_step(r_c, r_e, int'(r_m), int'(r_d), int'(r_s));
         check_state($sformatf("rnd%0d", i), m_q, m_sout, m_tc);
         if ($urandom_range(0, 49) == 0) begin
            #1 reset = 1'b1;
            model_reset();
            #1 check_state($sformatf("rnd_rst%0d", i), m_q, m_sout, m_tc);
            #1 reset = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/univ_reg.md
Name: univ_reg

Overview:
- Parametrised universal register: the next generation of the team's single-bit resettable D flip-flop with complementary output.
- Generalised to WIDTH bits, with an enable, a synchronous clear and an 8-mode operation select: hold, load, shift/rotate, count.
- Provides true and complementary outputs plus serial-out and terminal-count flags.
- Used as a shift register, counter or plain pipeline register in datapaths.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RST_VAL, {WIDTH{1'b0}}, value loaded on asynchronous reset and synchronous clear.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  operation enable; 0 = hold regardless of mode.
- clr  input  1  synchronous clear to RST_VAL; priority over en/mode.
- mode  input  3  operation select (encodings below).
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input for shift modes.
- q  output  WIDTH  register contents.
- q_n  output  WIDTH  bitwise complement of q, registered (never combinationally derived from q).
- sout  output  1  bit shifted out by the last shift, registered.
- tc  output  1  registered terminal-count flag.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - q=RST_VAL, q_n=~RST_VAL, sout=0, tc=0.
  - Takes effect without a clock edge and holds while reset is high.
- Priority at each rising clk edge: reset > clr > en==0 (hold) > mode.
- clr=1: q=RST_VAL, q_n=~RST_VAL, sout=0, tc=0; en and mode are ignored.
- Mode encodings (these are package constants):
  - 000 HOLD: q unchanged.
  - 001 LOAD: q=d.
  - 010 SHL: q={q[W-2:0],sin}; sout=old q[W-1].
  - 011 SHR: q={sin,q[W-1:1]}; sout=old q[0].
  - 100 ROL: q={q[W-2:0],q[W-1]}; sout=old q[W-1].
  - 101 ROR: q={q[0],q[W-1:1]}; sout=old q[0].
  - 110 INC: q=q+1, modulo 2^WIDTH; all-ones wraps to zero.
  - 111 DEC: q=q-1, modulo 2^WIDTH; zero wraps to all-ones.
- sout updates only in modes 010–101; it holds its value in every other mode and on hold.
- tc is a one-cycle pulse:
  - Set to 1 for exactly the cycle after an INC from all-ones or a DEC from zero (the wrap).
  - Cleared on every other edge where en=1.
  - Holds its value when en=0.
- Latency: every output reflects the operation one cycle after the sampling edge. No combinational path from any input to any output.
- Invariant: q_n == ~q at all times, including during and after reset.
- No illegal modes exist; all 8 encodings are defined.

Optional Feature:
- Macro: UNIV_REG_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit, registered) = ^(next q), updated on the same edge as q.
  - Reset/clear value is ^RST_VAL.
- Undefined:
  - The parity port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package univ_reg_pkg holds:
  - A 3-bit mode typedef with named constants MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC.
- Sub-module univ_reg_next: combinational next-state function.
  - Inputs: q, d, sin, mode.
  - Outputs: next q, next sout, wrap flag.
  - The top holds only the flops, the priority logic and the q_n/tc/parity registers.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5; assert reset between clock edges -> q=A5 and q_n=5A immediately; sout=0, tc=0.
- LOAD then shifts: load d=8'h81; SHL with sin=0 -> q=02, sout=1; SHR with sin=1 -> q=81, sout=0.
- Rotates: q=8'h81; ROL -> q=03, sout=1; ROR twice -> q=C0 after the first, then q=60, with sout=1 then sout=0.
- Count wrap: load FF; INC -> q=00, tc=1; INC -> q=01, tc=0. Load 00; DEC -> q=FF, tc=1.
- Priority: clr=1, en=1, mode=LOAD, d=3C -> q=RST_VAL. Then en=0, mode=INC for 3 cycles -> q, sout and tc unchanged.
- Reset mid-count: INC running with q=7E; assert reset for part of a cycle -> q=RST_VAL at once. After release, the first INC gives RST_VAL+1 and q_n tracks ~q throughout. With UNIV_REG_PARITY_EN defined, check parity==^q on every cycle.
